// File: rtl/regfile_sb.sv
// Integer register file with hardwired-zero x0, optional write-to-read bypass and a
// per-register reservation scoreboard with a registered count of outstanding producers.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            WE3,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            RSV,
    input  logic [AW-1:0]   RA,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            BUSY1,
    output logic            BUSY2,
    output logic [AW:0]     PENDING
);

    localparam logic BYP = (BYPASS != 0) ? 1'b1 : 1'b0;

    logic [XLEN-1:0] x_r [NREGS];
    logic [NREGS-1:0] b_r;
    logic [AW:0]      pending_r;

    logic             wr_en_s;
    logic             rsv_en_s;
    logic             set_s;
    logic             clr_s;
    logic [NREGS-1:0] b_next_s;
    logic [AW:0]      pending_next_s;
    logic [XLEN-1:0]  rd1_s;
    logic [XLEN-1:0]  rd2_s;
    logic             busy1_s;
    logic             busy2_s;

    // Qualify write/reserve requests and compute next scoreboard state and count delta.
    always_comb begin
        wr_en_s  = WE3 && (A3 != {AW{1'b0}});
        rsv_en_s = RSV && (RA != {AW{1'b0}});
        b_next_s = b_r;
        if (wr_en_s) begin
            b_next_s[A3] = 1'b0;
        end else begin
            b_next_s[A3] = b_r[A3];
        end
        if (rsv_en_s) begin
            b_next_s[RA] = 1'b1;
        end else begin
            b_next_s[RA] = b_next_s[RA];
        end
        // A release only counts if the bit was set and no reserve re-claims the same register.
        set_s = rsv_en_s && !b_r[RA];
        clr_s = wr_en_s && b_r[A3] && !(rsv_en_s && (RA == A3));
        pending_next_s = pending_r + {{AW{1'b0}}, set_s} - {{AW{1'b0}}, clr_s};
    end

    // Data storage; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                x_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            x_r[A3] <= WD3;
        end
    end

    // Scoreboard bits and outstanding-producer count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            b_r       <= {NREGS{1'b0}};
            pending_r <= {(AW + 1){1'b0}};
        end else begin
            b_r       <= b_next_s;
            pending_r <= pending_next_s;
        end
    end

    // Read port 1: zero for x0, forwarded writeback data when bypassing, else stored value.
    always_comb begin
        if (A1 == {AW{1'b0}}) begin
            rd1_s   = {XLEN{1'b0}};
            busy1_s = 1'b0;
        end else if (BYP && WE3 && (A3 == A1)) begin
            rd1_s   = WD3;
            busy1_s = (RSV && (RA == A1)) ? b_r[A1] : 1'b0;
        end else begin
            rd1_s   = x_r[A1];
            busy1_s = b_r[A1];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        if (A2 == {AW{1'b0}}) begin
            rd2_s   = {XLEN{1'b0}};
            busy2_s = 1'b0;
        end else if (BYP && WE3 && (A3 == A2)) begin
            rd2_s   = WD3;
            busy2_s = (RSV && (RA == A2)) ? b_r[A2] : 1'b0;
        end else begin
            rd2_s   = x_r[A2];
            busy2_s = b_r[A2];
        end
    end

    assign RD1     = rd1_s;
    assign RD2     = rd2_s;
    assign BUSY1   = busy1_s;
    assign BUSY2   = busy2_s;
    assign PENDING = pending_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: one bypassing and one non-bypassing instance
// share stimulus; a reference model feeds an expected-value queue checked each cycle.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk;
    logic            rst_n;
    logic            we3;
    logic [AW-1:0]   a1, a2, a3, ra;
    logic [XLEN-1:0] wd3;
    logic            rsv;

    logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic            busy1_b, busy2_b, busy1_n, busy2_n;
    logic [AW:0]     pend_b, pend_n;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_b (
        .CLK(clk), .RST_N(rst_n), .WE3(we3), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3),
        .RSV(rsv), .RA(ra), .RD1(rd1_b), .RD2(rd2_b), .BUSY1(busy1_b), .BUSY2(busy2_b),
        .PENDING(pend_b)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_n (
        .CLK(clk), .RST_N(rst_n), .WE3(we3), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3),
        .RSV(rsv), .RA(ra), .RD1(rd1_n), .RD2(rd2_n), .BUSY1(busy1_n), .BUSY2(busy2_n),
        .PENDING(pend_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [XLEN-1:0] mx [NREGS];
    logic            mb [NREGS];

    string           tag_q [$];
    logic [31:0]     exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mx[i] = 32'h0;
            mb[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_pending();
        logic [31:0] c;
        c = 32'd0;
        for (int i = 0; i < NREGS; i++) c += {31'd0, mb[i]};
        return c;
    endfunction

    function automatic logic [31:0] m_rd(input logic [AW-1:0] addr, input bit byp);
        if (addr == 5'd0) return 32'h0;
        if (byp && we3 && (a3 == addr)) return wd3;
        return mx[addr];
    endfunction

    function automatic logic [31:0] m_busy(input logic [AW-1:0] addr, input bit byp);
        if (addr == 5'd0) return 32'h0;
        if (byp && we3 && (a3 == addr) && !(rsv && (ra == addr))) return 32'h0;
        return {31'd0, mb[addr]};
    endfunction

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic r, input logic [AW-1:0] rad,
                         input logic [AW-1:0] p1, input logic [AW-1:0] p2);
        we3 = w; a3 = wa; wd3 = wd; rsv = r; ra = rad; a1 = p1; a2 = p2;
    endtask

    // Push expectations for the driven inputs, compare, then clock and advance the model.
    task automatic step();
        logic [31:0] obs [10];
        push("rd1_b", m_rd(a1, 1'b1));
        push("rd2_b", m_rd(a2, 1'b1));
        push("busy1_b", m_busy(a1, 1'b1));
        push("busy2_b", m_busy(a2, 1'b1));
        push("pend_b", m_pending());
        push("rd1_n", m_rd(a1, 1'b0));
        push("rd2_n", m_rd(a2, 1'b0));
        push("busy1_n", m_busy(a1, 1'b0));
        push("busy2_n", m_busy(a2, 1'b0));
        push("pend_n", m_pending());
        #1;
        obs[0] = rd1_b;  obs[1] = rd2_b;  obs[2] = {31'd0, busy1_b}; obs[3] = {31'd0, busy2_b};
        obs[4] = {26'd0, pend_b};
        obs[5] = rd1_n;  obs[6] = rd2_n;  obs[7] = {31'd0, busy1_n}; obs[8] = {31'd0, busy2_n};
        obs[9] = {26'd0, pend_n};
        for (int k = 0; k < 10; k++) begin
            check(tag_q.pop_front(), obs[k], exp_q.pop_front());
        end
        @(posedge clk);
        if (we3 && (a3 != 5'd0)) begin
            mx[a3] = wd3;
            mb[a3] = 1'b0;
        end
        if (rsv && (ra != 5'd0)) mb[ra] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_reset();
        #1;
        check("reset_rd1", rd1_b, 32'h0);
        check("reset_pend", {26'd0, pend_b}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while holding state: write x5, reserve x6, then assert reset between edges
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 5'd5, 5'd6);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        #1;
        check("pre_rst_rd1", rd1_b, 32'hDEADBEEF);
        check("pre_rst_pend", {26'd0, pend_b}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_rd1", rd1_b, 32'h0);
        check("rst_pend", {26'd0, pend_b}, 32'd0);
        check("rst_busy2", {31'd0, busy2_b}, 32'd0);
        // Write and reserve attempted during reset must be discarded
        drive(1'b1, 5'd5, 32'h12345678, 1'b1, 5'd5, 5'd5, 5'd6);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        #1;
        check("rst_discard_rd1", rd1_n, 32'h0);
        check("rst_discard_busy", {31'd0, busy1_n}, 32'd0);
        @(negedge clk);

        // x0 protection
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        check("x0_rd1", rd1_b, 32'h0);
        check("x0_busy1", {31'd0, busy1_b}, 32'd0);
        check("x0_pend", {26'd0, pend_b}, 32'd0);
        @(negedge clk);

        // Bypass vs stored-only read of x7
        drive(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        check("byp_rd1", rd1_b, 32'h22);
        check("byp_rd2", rd2_b, 32'h22);
        check("nobyp_rd1", rd1_n, 32'h11);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        check("post_wr_rd1_b", rd1_b, 32'h22);
        check("post_wr_rd2_n", rd2_n, 32'h22);
        @(negedge clk);

        // Reserve x3 then x4, release x3
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
        step();
        #1;
        check("rsv3_pend", {26'd0, pend_b}, 32'd1);
        check("rsv3_busy1", {31'd0, busy1_b}, 32'd1);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4);
        step();
        #1;
        check("rsv4_pend", {26'd0, pend_b}, 32'd2);
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h5, 1'b0, 5'd0, 5'd3, 5'd4);
        #1;
        check("rel3_busy1_b", {31'd0, busy1_b}, 32'd0);
        check("rel3_busy1_n", {31'd0, busy1_n}, 32'd1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        #1;
        check("rel3_pend", {26'd0, pend_b}, 32'd1);
        check("rel3_rd1", rd1_n, 32'h5);
        check("rel3_busy2", {31'd0, busy2_n}, 32'd1);
        @(negedge clk);

        // Simultaneous write and reserve on busy x9
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 5'd9, 5'd4);
        step();
        drive(1'b1, 5'd9, 32'hA5, 1'b1, 5'd9, 5'd9, 5'd4);
        #1;
        check("same_pre_busy_b", {31'd0, busy1_b}, 32'd1);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd4);
        #1;
        check("same_rd1", rd1_n, 32'hA5);
        check("same_busy1", {31'd0, busy1_n}, 32'd1);
        check("same_pend", {26'd0, pend_n}, 32'd1);
        @(negedge clk);
        drive(1'b1, 5'd9, 32'hA6, 1'b0, 5'd0, 5'd9, 5'd0);
        step();

        // Saturation: reserve all, re-reserve, release all
        for (int i = 1; i < NREGS; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, i[AW-1:0], i[AW-1:0], 5'd0);
            step();
        end
        drive(1'b1, 5'd0, 32'h0, 1'b1, 5'd1, 5'd1, 5'd31);
        step();
        #1;
        check("sat_pend", {26'd0, pend_b}, 32'd31);
        @(negedge clk);
        for (int i = 1; i < NREGS; i++) begin
            drive(1'b1, i[AW-1:0], 32'h100 + i, 1'b0, 5'd0, i[AW-1:0], 5'd31);
            step();
        end
        #1;
        check("drain_pend", {26'd0, pend_n}, 32'd0);
        @(negedge clk);

        // Random traffic through the scoreboard
        for (int n = 0; n < 200; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (n % 3 == 0) a1 = a3;
            if (n % 5 == 0) a2 = ra;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with hardwired-zero register 0, asynchronous clear, and optional write-to-read bypass. Each register also has a reservation scoreboard, so pipelined decode can detect outstanding producers. Sits between decode (read and reserve) and writeback (write and release) in the pipelined core. It replaces the single-cycle register file as the default register storage.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, register count; power of two, ≥ 2; address width AW = log2(NREGS).
- BYPASS, 1; 1 = same-cycle writeback data and release visible on read ports; 0 = reads see stored state only.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- WE3  in  1  write enable; also releases reservation of A3.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- A3  in  AW  write address.
- WD3  in  XLEN  write data.
- RSV  in  1  reserve request: marks RA as having an in-flight producer.
- RA  in  AW  reserve address.
- RD1  out  XLEN  read data, port 1.
- RD2  out  XLEN  read data, port 2.
- BUSY1  out  1  register A1 has an outstanding reservation.
- BUSY2  out  1  register A2 has an outstanding reservation.
- PENDING  out  AW+1  number of registers currently reserved.

## Operation
- Storage: NREGS × XLEN data registers x[i], plus NREGS busy bits b[i], plus a PENDING counter.
- Register 0:
  - Reads always return 0 and are never busy.
  - Writes and reservations to address 0 are ignored; they do not change PENDING.
- Read ports are combinational:
  - RDn = x[An] for An ≠ 0.
  - With BYPASS=1 and WE3=1, A3=An≠0: RDn = WD3.
- Busy outputs:
  - BUSYn = b[An].
  - With BYPASS=1, a same-cycle release (WE3=1, A3=An) forces BUSYn=0, unless RSV=1 and RA=An in that same cycle.
- Write: on rising CLK with WE3=1 and A3≠0, x[A3] ← WD3, b[A3] ← 0.
- Reserve: on rising CLK with RSV=1 and RA≠0, b[RA] ← 1.
- Simultaneous WE3 and RSV:
  - Different addresses: both apply.
  - Same nonzero address: data is written, and the busy bit ends at 1 (the new producer wins).
- Reserving an already-busy register leaves b=1; count unchanged.
- Releasing a non-busy register writes data; b stays 0; count unchanged.
- PENDING always equals the population count of b[]. Update per edge as +1 for a 0→1 transition and −1 for a 1→0 transition; both may occur in one cycle (net 0).
- PENDING range is 0..NREGS−1 and it never wraps; maximum NREGS−1 because x0 is excluded.

## Timing
- Reset values (asynchronous, immediate on RST_N=0): all x[i]=0, all b[i]=0, PENDING=0. Consequently RD1=RD2=0 and BUSY1=BUSY2=0.
- Reset asserted mid-operation discards any pending write or reserve in that cycle.
- First update occurs on the first rising CLK after RST_N is deasserted.
- Read latency: 0 cycles (combinational from An, and from WE3/A3/WD3 when BYPASS=1).
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle with BYPASS=0.
- Reserve-to-busy latency: 1 cycle (BUSYn reflects RSV after the edge; no same-cycle forwarding of RSV).
- PENDING is registered; it updates on the same edge as b[].

## Test plan
- Reset: hold RST_N=0 after writing 0xDEADBEEF to x5, with no CLK edge required. Required: RD1 (A1=5) = 0, PENDING=0, BUSY1=0.
- x0 protection: WE3=1, A3=0, WD3=0xFFFFFFFF; RSV=1, RA=0. Required: RD1 (A1=0) = 0 before and after the edge, BUSY1=0, PENDING=0.
- Bypass (BYPASS=1):
  - x7 holds 0x11. Drive WE3=1, A3=7, WD3=0x22, A1=A2=7. Required: RD1=RD2=0x22 in the same cycle, and 0x22 after the edge.
  - With BYPASS=0: 0x11 in the same cycle, 0x22 after the edge.
- Scoreboard sequence: RSV on x3, then RSV on x4. Required: PENDING=1, then 2; BUSY1 (A1=3) = 1. Then WE3 on x3 with WD3=0x5. Required: BUSY1=0 in the same cycle (BYPASS=1), PENDING=1 after the edge, RD1=0x5.
- Simultaneous same address: x9 busy, PENDING=1. Drive WE3=1, A3=9, WD3=0xA5 and RSV=1, RA=9. Required after the edge: x9=0xA5, BUSY (A1=9) = 1, PENDING=1.
- Saturation: reserve all of x1..x31 over 31 cycles. Required: PENDING=31. Then reserve x1 again: PENDING stays 31. Then release all of x1..x31: PENDING returns to 0 with no wrap.
